iotdf_seq_ctrl: RTL and testbench
=================================

# iotdf_seq_ctrl

Input sequencer for the IoT data-filter datapath. Accepts a byte stream under a busy/in_en handshake and packs every 16 bytes into a 128-bit word. Tags each word with its position in an 8-word round and presents it to the filter datapath over a valid/ready handshake. Runs a job of a programmed number of rounds with one function select latched per job, then reports completion.

## Interface
- BYTE_W, 8, input byte width
- BYTES_PER_WORD, 16, bytes packed per output word
- WORDS_PER_ROUND, 8, words per round (power of two)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  job request; honored only in IDLE
- fn_sel  in  3  function select; sampled with accepted start
- num_rounds  in  8  rounds in job; sampled with accepted start
- in_en  in  1  byte strobe from source
- iot_in  in  BYTE_W  input byte
- busy  out  1  high = bytes not accepted this cycle
- word  out  BYTE_W*BYTES_PER_WORD  packed word; first byte in bits [127:120]
- word_vld  out  1  word valid
- word_rdy  in  1  datapath accepts word
- word_idx  out  3  index of word within round, 0..7
- word_first  out  1  word_idx == 0
- word_last  out  1  word_idx == WORDS_PER_ROUND-1
- round_idx  out  8  current round, 0-based
- fn  out  3  latched function select
- active  out  1  job in progress
- done  out  1  one-cycle pulse at job completion
- err  out  1  sticky protocol error

## Operation
- States: IDLE, FILL, HOLD, DONE.
- IDLE: busy=1, active=0. With start=1, latch fn_sel and num_rounds, clear err and counters, then go to FILL. If num_rounds==0, go directly to DONE instead.
- FILL: busy=0, active=1. Each cycle with in_en=1 shifts iot_in into the packer and increments byte_cnt (4 bits). On the 16th byte (byte_cnt==15 and in_en), register the word and go to HOLD.
- HOLD: busy=1, word_vld=1, word stable. On word_vld&word_rdy:
  - word_idx increments, wrapping 7→0.
  - On wrap, round_idx increments.
  - If word_last and round_idx==num_rounds-1, go to DONE; otherwise go to FILL.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE. fn and round_idx hold their values until the next start.
- Protocol errors:
  - in_en=1 while busy=1 (any state) sets err; the byte is discarded.
  - start outside IDLE is ignored and does not set err.
- fn_sel and num_rounds changes after start have no effect until the next accepted start.

## Timing
- Reset values: busy=1, word_vld=0, word=0, word_idx=0, word_first=1, word_last=0, round_idx=0, fn=0, active=0, done=0, err=0, state=IDLE.
- start accepted in cycle t: busy=0 in cycle t+1.
- 16th byte in cycle t: word_vld=1 and busy=1 in cycle t+1. All outputs are registered; there is no combinational path from in_en to busy.
- Handshake in cycle t: word_vld=0 in t+1. Either busy=0 (FILL) or done=1 (DONE) in t+1.
- word_rdy held high: minimum period is 17 cycles per word (16 byte cycles plus 1 HOLD cycle).
- word_rdy low: word, word_idx, round_idx and fn are held stable indefinitely.
- rst asserted mid-job: immediate return to reset values. The partial word is lost and done is not pulsed.
- num_rounds=255: 2040 words, then done. round_idx never exceeds num_rounds-1.

## Structure
- Shared package iotdf_pkg holds:
  - state enum
  - BYTE_W, BYTES_PER_WORD, WORDS_PER_ROUND
  - fn_sel code constants (shared with the filter datapath)
- Sub-module iotdf_byte_packer: 128-bit shift register with byte counter. Inputs: shift enable, clear. Outputs: word_full strobe, packed word.
- Top level: FSM, word/round counters, output registers.

## Test plan
- Reset mid-HOLD with word_vld=1 → next cycle all outputs at reset values, busy=1, no done.
- start with fn_sel=3, num_rounds=1, then 128 bytes 0x00..0x7F, word_rdy=1 →
  - 8 words with word_idx 0..7.
  - Word 0 = 0x000102…0F.
  - word_last only on word 7.
  - done one cycle after the 8th handshake; fn=3 throughout.
- num_rounds=2, word_rdy low for 5 cycles on word 3 → busy=1 and word stable for 5 cycles. Later, round_idx steps 0→1 after the 8th handshake; 16 words total, then done.
- in_en pulsed during HOLD with byte 0xAA → err=1, 0xAA absent from the next word. err cleared by the next accepted start.
- num_rounds=0 with start → done one cycle after start, no word_vld, busy stays 1.
- start with fn_sel=5, then fn_sel changed to 1 mid-job, and start re-asserted during FILL → fn stays 5, job continues unaffected.

Source files
------------

// File: rtl/iotdf_pkg.sv
// Shared definitions for the IoT data-filter input sequencer and datapath.
package iotdf_pkg;

  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_WORD  = 16;
  localparam int WORDS_PER_ROUND = 8;
  localparam int WORD_W          = BYTE_W * BYTES_PER_WORD;
  localparam int CNT_W           = $clog2(BYTES_PER_WORD);
  localparam int IDX_W           = $clog2(WORDS_PER_ROUND);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_HOLD,
    ST_DONE
  } state_e;

  // Function select codes understood by the filter datapath
  localparam logic [2:0] FN_NONE     = 3'd0;
  localparam logic [2:0] FN_MAX      = 3'd1;
  localparam logic [2:0] FN_MIN      = 3'd2;
  localparam logic [2:0] FN_AVG      = 3'd3;
  localparam logic [2:0] FN_EXTRACT  = 3'd4;
  localparam logic [2:0] FN_EXCLUDE  = 3'd5;
  localparam logic [2:0] FN_PEAK_MAX = 3'd6;
  localparam logic [2:0] FN_PEAK_MIN = 3'd7;

endpackage

// File: rtl/iotdf_byte_packer.sv
// Byte-to-word shift register; first byte shifted in ends up in the top byte lane.
module iotdf_byte_packer
  import iotdf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              clear,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_full,
  output logic [WORD_W-1:0] word_next
);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shreg_d = {shreg_q[WORD_W-BYTE_W-1:0], byte_in};
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // word_next already includes the byte arriving this cycle, so the owner can
  // capture the completed word on the same edge the 16th byte is accepted.
  assign word_next = {shreg_q[WORD_W-BYTE_W-1:0], byte_in};
  assign word_full = shift_en && !clear && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/iotdf_seq_ctrl.sv
// Input sequencer: packs bytes into words, tags them with word/round position
// and hands them to the filter datapath for a programmed number of rounds.
module iotdf_seq_ctrl
  import iotdf_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          fn_sel,
  input  logic [7:0]          num_rounds,
  input  logic                in_en,
  input  logic [BYTE_W-1:0]   iot_in,
  output logic                busy,
  output logic [WORD_W-1:0]   word,
  output logic                word_vld,
  input  logic                word_rdy,
  output logic [IDX_W-1:0]    word_idx,
  output logic                word_first,
  output logic                word_last,
  output logic [7:0]          round_idx,
  output logic [2:0]          fn,
  output logic                active,
  output logic                done,
  output logic                err
);

  state_e            state_q, state_d;
  logic [2:0]        fn_q, fn_d;
  logic [7:0]        nrounds_q, nrounds_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [7:0]        round_idx_q, round_idx_d;
  logic              busy_q, busy_d;
  logic              word_vld_q, word_vld_d;
  logic              word_first_q, word_first_d;
  logic              word_last_q, word_last_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              start_acc;
  logic              shift_en;
  logic              word_full;
  logic [WORD_W-1:0] word_next;
  logic              last_round;

  assign start_acc  = (state_q == ST_IDLE) && start;
  assign shift_en   = (state_q == ST_FILL) && in_en;
  assign last_round = (round_idx_q == nrounds_q - 8'd1);

  iotdf_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .clear     (start_acc),
    .byte_in   (iot_in),
    .word_full (word_full),
    .word_next (word_next)
  );

  always_comb begin
    state_d     = state_q;
    fn_d        = fn_q;
    nrounds_d   = nrounds_q;
    word_d      = word_q;
    word_idx_d  = word_idx_q;
    round_idx_d = round_idx_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          fn_d        = fn_sel;
          nrounds_d   = num_rounds;
          err_d       = 1'b0;
          word_idx_d  = '0;
          round_idx_d = '0;
          state_d     = (num_rounds == 8'd0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (word_full) begin
          word_d  = word_next;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (word_rdy) begin
          word_idx_d = word_idx_q + IDX_W'(1);
          state_d    = ST_FILL;
          // round_idx is frozen on the final word so it never passes num_rounds-1
          if (word_idx_q == IDX_W'(WORDS_PER_ROUND - 1)) begin
            if (last_round) begin
              state_d = ST_DONE;
            end else begin
              round_idx_d = round_idx_q + 8'd1;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A byte offered while busy is dropped and flagged; this wins over a start clear.
    if (in_en && busy_q) begin
      err_d = 1'b1;
    end

    busy_d       = (state_d != ST_FILL);
    word_vld_d   = (state_d == ST_HOLD);
    active_d     = (state_d == ST_FILL) || (state_d == ST_HOLD);
    done_d       = (state_d == ST_DONE);
    word_first_d = (word_idx_d == '0);
    word_last_d  = (word_idx_d == IDX_W'(WORDS_PER_ROUND - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fn_q         <= FN_NONE;
      nrounds_q    <= '0;
      word_q       <= '0;
      word_idx_q   <= '0;
      round_idx_q  <= '0;
      busy_q       <= 1'b1;
      word_vld_q   <= 1'b0;
      word_first_q <= 1'b1;
      word_last_q  <= 1'b0;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fn_q         <= fn_d;
      nrounds_q    <= nrounds_d;
      word_q       <= word_d;
      word_idx_q   <= word_idx_d;
      round_idx_q  <= round_idx_d;
      busy_q       <= busy_d;
      word_vld_q   <= word_vld_d;
      word_first_q <= word_first_d;
      word_last_q  <= word_last_d;
      active_q     <= active_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign busy       = busy_q;
  assign word       = word_q;
  assign word_vld   = word_vld_q;
  assign word_idx   = word_idx_q;
  assign word_first = word_first_q;
  assign word_last  = word_last_q;
  assign round_idx  = round_idx_q;
  assign fn         = fn_q;
  assign active     = active_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_iotdf_seq_ctrl.sv
// Directed bench for iotdf_seq_ctrl: packing, word/round tagging, stalls,
// protocol errors, restart immunity, mid-job reset and zero-round jobs.
module tb_iotdf_seq_ctrl;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   fn_sel;
  logic [7:0]   num_rounds;
  logic         in_en;
  logic [7:0]   iot_in;
  logic         busy;
  logic [127:0] word;
  logic         word_vld;
  logic         word_rdy;
  logic [2:0]   word_idx;
  logic         word_first;
  logic         word_last;
  logic [7:0]   round_idx;
  logic [2:0]   fn;
  logic         active;
  logic         done;
  logic         err;

  int total = 0;
  int bad   = 0;

  iotdf_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fn_sel     (fn_sel),
    .num_rounds (num_rounds),
    .in_en      (in_en),
    .iot_in     (iot_in),
    .busy       (busy),
    .word       (word),
    .word_vld   (word_vld),
    .word_rdy   (word_rdy),
    .word_idx   (word_idx),
    .word_first (word_first),
    .word_last  (word_last),
    .round_idx  (round_idx),
    .fn         (fn),
    .active     (active),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected packing of 16 consecutive bytes starting at base, first byte on top.
  function automatic logic [127:0] pat(input logic [7:0] base);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], 8'(base + 8'(i))};
    return r;
  endfunction

  task automatic send_word(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      in_en  = 1'b1;
      iot_in = 8'(base + 8'(i));
      tick();
    end
    in_en = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},  128'(busy),       128'd1);
    chk({tag, "_vld"},   128'(word_vld),   128'd0);
    chk({tag, "_word"},  word,             128'd0);
    chk({tag, "_idx"},   128'(word_idx),   128'd0);
    chk({tag, "_first"}, 128'(word_first), 128'd1);
    chk({tag, "_last"},  128'(word_last),  128'd0);
    chk({tag, "_round"}, 128'(round_idx),  128'd0);
    chk({tag, "_fn"},    128'(fn),         128'd0);
    chk({tag, "_act"},   128'(active),     128'd0);
    chk({tag, "_done"},  128'(done),       128'd0);
    chk({tag, "_err"},   128'(err),        128'd0);
  endtask

  initial begin
    logic [7:0] base;
    rst = 1'b1; start = 1'b0; fn_sel = 3'd0; num_rounds = 8'd0;
    in_en = 1'b0; iot_in = 8'd0; word_rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_reset("rst");

    // Job A: fn 3, one round, bytes 0x00..0x7F
    start = 1'b1; fn_sel = 3'd3; num_rounds = 8'd1;
    tick();
    start = 1'b0; fn_sel = 3'd0; num_rounds = 8'd0;
    chk("a_busy_after_start", 128'(busy), 128'd0);
    chk("a_active", 128'(active), 128'd1);
    chk("a_fn", 128'(fn), 128'd3);
    for (int w = 0; w < 8; w++) begin
      base = 8'(w * 16);
      send_word(base);
      $display("job A word %0d idx %0d round %0d data %h", w, word_idx, round_idx, word);
      chk("a_vld", 128'(word_vld), 128'd1);
      chk("a_busy_hold", 128'(busy), 128'd1);
      chk("a_word", word, pat(base));
      chk("a_idx", 128'(word_idx), 128'(w));
      chk("a_first", 128'(word_first), 128'(w == 0));
      chk("a_last", 128'(word_last), 128'(w == 7));
      chk("a_fn_hold", 128'(fn), 128'd3);
      chk("a_round", 128'(round_idx), 128'd0);
      word_rdy = 1'b1;
      tick();
      word_rdy = 1'b0;
      chk("a_vld_after_hs", 128'(word_vld), 128'd0);
      if (w < 7) chk("a_busy_after_hs", 128'(busy), 128'd0);
      else       chk("a_done_pulse", 128'(done), 128'd1);
    end
    tick();
    chk("a_done_clear", 128'(done), 128'd0);
    chk("a_busy_idle", 128'(busy), 128'd1);
    chk("a_round_end", 128'(round_idx), 128'd0);
    chk("a_fn_end", 128'(fn), 128'd3);

    // Job B: two rounds with a 5-cycle stall on word 3
    start = 1'b1; fn_sel = 3'd2; num_rounds = 8'd2;
    tick();
    start = 1'b0;
    for (int w = 0; w < 16; w++) begin
      base = 8'(w * 16 + 3);
      send_word(base);
      $display("job B word %0d idx %0d round %0d data %h", w, word_idx, round_idx, word);
      chk("b_word", word, pat(base));
      chk("b_idx", 128'(word_idx), 128'(w % 8));
      chk("b_round", 128'(round_idx), 128'(w / 8));
      chk("b_last", 128'(word_last), 128'((w % 8) == 7));
      if (w == 3) begin
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("b_stall_busy", 128'(busy), 128'd1);
          chk("b_stall_vld", 128'(word_vld), 128'd1);
          chk("b_stall_word", word, pat(base));
          chk("b_stall_idx", 128'(word_idx), 128'd3);
        end
      end
      word_rdy = 1'b1;
      tick();
      word_rdy = 1'b0;
      chk("b_round_after_hs", 128'(round_idx), 128'((w >= 7) ? 1 : 0));
      if (w < 15) chk("b_busy_after_hs", 128'(busy), 128'd0);
      else        chk("b_done_pulse", 128'(done), 128'd1);
    end
    tick();
    chk("b_done_clear", 128'(done), 128'd0);

    // Job C: byte offered during HOLD is dropped and flagged
    start = 1'b1; fn_sel = 3'd2; num_rounds = 8'd1;
    tick();
    start = 1'b0;
    for (int w = 0; w < 8; w++) begin
      base = 8'(8'h40 + w * 16);
      send_word(base);
      $display("job C word %0d idx %0d data %h err %0d", w, word_idx, word, err);
      chk("c_word", word, pat(base));
      if (w == 0) begin
        in_en = 1'b1; iot_in = 8'hAA;
        tick();
        in_en = 1'b0;
        chk("c_err_set", 128'(err), 128'd1);
        chk("c_word_kept", word, pat(base));
        chk("c_vld_kept", 128'(word_vld), 128'd1);
      end
      word_rdy = 1'b1;
      tick();
      word_rdy = 1'b0;
    end
    chk("c_done_pulse", 128'(done), 128'd1);
    chk("c_err_sticky", 128'(err), 128'd1);
    tick();

    // Job D: fn latched at start; later start/fn_sel changes ignored; then reset mid-HOLD
    start = 1'b1; fn_sel = 3'd5; num_rounds = 8'd3;
    tick();
    start = 1'b0; fn_sel = 3'd1;
    chk("d_err_cleared", 128'(err), 128'd0);
    chk("d_fn", 128'(fn), 128'd5);
    for (int i = 0; i < 16; i++) begin
      in_en = 1'b1;
      iot_in = 8'(8'h90 + 8'(i));
      start = (i < 4);
      tick();
    end
    in_en = 1'b0; start = 1'b0;
    $display("job D word 0 idx %0d data %h fn %0d", word_idx, word, fn);
    chk("d_word", word, pat(8'h90));
    chk("d_fn_hold", 128'(fn), 128'd5);
    chk("d_idx0", 128'(word_idx), 128'd0);
    chk("d_err_none", 128'(err), 128'd0);
    chk("d_vld", 128'(word_vld), 128'd1);
    word_rdy = 1'b1;
    tick();
    word_rdy = 1'b0;
    chk("d_busy_after_hs", 128'(busy), 128'd0);
    send_word(8'hC0);
    chk("d_idx1", 128'(word_idx), 128'd1);
    chk("d_vld1", 128'(word_vld), 128'd1);
    rst = 1'b1;
    tick();
    chk_reset("d_rst");
    rst = 1'b0;
    tick();
    chk("d_no_done", 128'(done), 128'd0);
    chk("d_idle_busy", 128'(busy), 128'd1);

    // Job E: zero rounds goes straight to DONE
    start = 1'b1; fn_sel = 3'd4; num_rounds = 8'd0;
    tick();
    start = 1'b0;
    chk("e_done", 128'(done), 128'd1);
    chk("e_vld", 128'(word_vld), 128'd0);
    chk("e_busy", 128'(busy), 128'd1);
    chk("e_fn", 128'(fn), 128'd4);
    tick();
    chk("e_done_clear", 128'(done), 128'd0);
    chk("e_busy_idle", 128'(busy), 128'd1);
    chk("e_vld_idle", 128'(word_vld), 128'd0);
    chk("e_active", 128'(active), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
